// File: rtl/e203_reset_req_gen.sv
// ---------------------------------------------------------------------------
// e203_reset_req_gen
//
// Always-on reset request generator. Collects the system reset requests
// (watchdog, software, debug ndmreset) and drives a stretched, glitch-free
// active-low request toward the reset controller. It then watches the
// synchronized core reset to confirm that the reset was taken and released,
// and enforces a hold-off window before it accepts a new request.
//
// This block lives in the AON domain. It is reset only by power-on reset and
// never by its own output.
//
// Optional feature: define E203_RST_REQ_CAUSE_EN to add sticky reset-cause
// bits (rst_cause = {dbg, sw, wdg}) and a clear input (rst_cause_clr).
//
// Ports:
//   clk            in   AON clock
//   rst_n          in   power-on reset, synchronous, active-low
//   wdg_rst_req    in   watchdog reset request (level)
//   sw_rst_req     in   software reset request (single-cycle pulse)
//   dbg_ndmreset   in   debug non-debug-module reset (level)
//   core_rst_n_obs in   core reset synchronized into clk, 0 = core in reset
//   rst_cause_clr  in   clears rst_cause (E203_RST_REQ_CAUSE_EN only)
//   rst_cause      out  sticky {dbg, sw, wdg} cause (E203_RST_REQ_CAUSE_EN only)
//   sys_rst_req_n  out  registered reset request, 0 = request reset
//   rst_busy       out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module e203_reset_req_gen #(
   parameter int unsigned PULSE_CYCLES   = 16,
   parameter int unsigned HOLDOFF_CYCLES = 8,
   parameter int unsigned ACK_TIMEOUT    = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wdg_rst_req,
   input  logic       sw_rst_req,
   input  logic       dbg_ndmreset,
   input  logic       core_rst_n_obs,
`ifdef E203_RST_REQ_CAUSE_EN
   input  logic       rst_cause_clr,
   output logic [2:0] rst_cause,
`endif
   output logic       sys_rst_req_n,
   output logic       rst_busy
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ASSERT   = 2'd1,
      ST_WAIT_REL = 2'd2,
      ST_HOLDOFF  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(HOLDOFF_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACK_TIMEOUT - 32'd1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             sys_rst_req_n_q, sys_rst_req_n_d;
   logic             rst_busy_q, rst_busy_d;

   logic             req_any;
   logic             req_lvl;
   logic             pulse_done;
   logic             to_expired;

   // Only the level requests can outlive a busy period; sw pulses are lost.
   assign req_any    = wdg_rst_req | sw_rst_req | dbg_ndmreset;
   assign req_lvl    = wdg_rst_req | dbg_ndmreset;
   assign pulse_done = (pulse_cnt_q == CNT_ZERO);
   assign to_expired = (to_cnt_q == TO_LAST);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      pulse_cnt_d = pulse_cnt_q;
      to_cnt_d    = to_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               state_d     = ST_ASSERT;
               pulse_cnt_d = PULSE_INIT;
               to_cnt_d    = CNT_ZERO;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_ASSERT: begin
            // Release needs the minimum pulse, no level request, and either
            // the core seen in reset or the acknowledge timeout.
            if (pulse_done && !req_lvl && (!core_rst_n_obs || to_expired)) begin
               state_d  = ST_WAIT_REL;
               to_cnt_d = CNT_ZERO;
            end else begin
               if (!pulse_done) begin
                  pulse_cnt_d = pulse_cnt_q - CNT_ONE;
               end else begin
                  pulse_cnt_d = CNT_ZERO;
               end
               // The timeout only runs once nothing else is holding the pulse.
               if (pulse_done && !req_lvl && !to_expired) begin
                  to_cnt_d = to_cnt_q + CNT_ONE;
               end else begin
                  to_cnt_d = to_cnt_q;
               end
            end
         end
         ST_WAIT_REL: begin
            if (core_rst_n_obs || to_expired) begin
               state_d     = ST_HOLDOFF;
               pulse_cnt_d = HOLD_INIT;
            end else begin
               to_cnt_d    = to_cnt_q + CNT_ONE;
            end
         end
         ST_HOLDOFF: begin
            if (pulse_done) begin
               state_d  = ST_IDLE;
               to_cnt_d = CNT_ZERO;
            end else begin
               pulse_cnt_d = pulse_cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            pulse_cnt_d = CNT_ZERO;
            to_cnt_d    = CNT_ZERO;
         end
      endcase

      // Outputs are decoded from the next state so they register with it.
      sys_rst_req_n_d = (state_d != ST_ASSERT);
      rst_busy_d      = (state_d != ST_IDLE);
   end

   // State, counters and output flops with synchronous power-on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         pulse_cnt_q     <= CNT_ZERO;
         to_cnt_q        <= CNT_ZERO;
         sys_rst_req_n_q <= 1'b1;
         rst_busy_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         pulse_cnt_q     <= pulse_cnt_d;
         to_cnt_q        <= to_cnt_d;
         sys_rst_req_n_q <= sys_rst_req_n_d;
         rst_busy_q      <= rst_busy_d;
      end
   end

   assign sys_rst_req_n = sys_rst_req_n_q;
   assign rst_busy      = rst_busy_q;

`ifdef E203_RST_REQ_CAUSE_EN
   logic [2:0] rst_cause_q, rst_cause_d;
   logic [2:0] cause_set;

   // Cause capture: set bits are applied after the clear so a set wins.
   always_comb begin
      if ((state_q == ST_IDLE) && req_any) begin
         cause_set = {dbg_ndmreset, sw_rst_req, wdg_rst_req};
      end else begin
         cause_set = 3'b000;
      end
      if (rst_cause_clr) begin
         rst_cause_d = cause_set;
      end else begin
         rst_cause_d = rst_cause_q | cause_set;
      end
   end

   // Sticky cause register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_cause_q <= 3'b000;
      end else begin
         rst_cause_q <= rst_cause_d;
      end
   end

   assign rst_cause = rst_cause_q;
`endif

endmodule
